matram_writeback_lane: RTL and testbench
========================================

Name: matram_writeback_lane

Overview:
- Write-side counterpart of the MatRAM lane address sequencer: collects one lane's MAU result elements and writes them into MatRAM at consecutive addresses from a programmed base.
- Sits between one MAU output lane and one MatRAM write port.
- Buffers results in a small FIFO so MAU output cadence and MatRAM write-grant stalls are decoupled.
- Signals completion once all elements of the lane are committed.

Parameters:
- ADDR_W, 10, MatRAM address width.
- DATA_W, 16, result element width.
- LANE_ELEMS, 4, elements written per operation (≥1).
- FIFO_DEPTH, 4, result buffer depth (power of 2, ≥2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- set_address  in  1  load base address from address_in (IDLE only).
- address_in  in  ADDR_W  base address value.
- wb_start  in  1  arm a write-back operation.
- res_valid  in  1  MAU result element valid.
- res_data  in  DATA_W  MAU result element.
- res_ready  out  1  block accepts res_data this cycle.
- mem_grant  in  1  MatRAM write port available this cycle.
- mem_we  out  1  MatRAM write enable.
- mem_addr  out  ADDR_W  MatRAM write address.
- mem_wdata  out  DATA_W  MatRAM write data.
- busy  out  1  operation in progress (state ACTIVE).
- done  out  1  one-cycle pulse after the final write.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: state=IDLE, base=0, accept_cnt=0, write_idx=0, FIFO empty, done=0. res_ready, mem_we and busy are 0 in the cycle after reset.
- States: IDLE, ACTIVE.
- IDLE:
  - set_address=1 loads base<=address_in.
  - wb_start=1 moves to ACTIVE and clears accept_cnt and write_idx.
  - If both are high in the same cycle, the new base is used.
- ACTIVE:
  - set_address and wb_start are ignored.
  - busy=1.
- Accept side:
  - res_ready = ACTIVE && !fifo_full && accept_cnt<LANE_ELEMS.
  - A push happens when res_valid && res_ready; accept_cnt increments on each push.
  - res_valid while res_ready=0 is dropped without error. The MAU holds data until ready.
  - On a full FIFO, res_ready stays 0 even if a pop occurs in the same cycle.
- Write side (combinational from FIFO head):
  - mem_we = ACTIVE && !fifo_empty && mem_grant.
  - mem_addr = (base + write_idx) mod 2^ADDR_W, so addresses wrap at the top of the space.
  - mem_wdata = FIFO head.
  - When mem_we=1, the FIFO pops and write_idx increments.
  - When mem_we=0, mem_addr and mem_wdata are don't-care.
- Latency: an element accepted at edge N is writable in cycle N+1 at the earliest. Writes preserve acceptance order.
- Completion: the final write (write_idx==LANE_ELEMS-1 with mem_we=1) causes, at that edge:
  - state<=IDLE;
  - done<=1 for exactly one cycle;
  - the base is retained, so a repeat wb_start reuses it.
- Stalls: mem_grant=0 holds the FIFO head and write_idx. No element is lost or duplicated.
- Reset mid-operation: the FIFO is flushed, the base is cleared, and there is no mem_we or done in the following cycle. Partial writes already issued are not rolled back.
- Width rules: write_idx and accept_cnt are $clog2(LANE_ELEMS+1) bits. Address addition truncates to ADDR_W.

Decomposition:
- Package mau_pkg holds:
  - ADDR_W, DATA_W, LANE_ELEMS defaults;
  - wb_state_t enum {IDLE, ACTIVE};
  - an addr_t typedef.
- One sub-module: matram_wb_fifo. It is a synchronous FIFO with parameters DATA_W and FIFO_DEPTH, ports push, pop, din, dout, full and empty. It uses registered pointers and a first-word-visible head.

Test Plan:
- Reset check: assert reset 2 cycles, then release → res_ready=0, mem_we=0, busy=0, done=0. wb_start with no set_address then writes from address 0x000.
- Back-to-back stream: set_address=0x100, wb_start at cycle T, mem_grant=1, results A,B,C,D offered continuously.
  - Accepted at T+1..T+4.
  - mem_we at T+2..T+5 with addr 0x100..0x103 and data A..D.
  - done=1 at T+6 only; busy=0 from T+6.
- Grant stall: same stream with mem_grant=0 from T+1 to T+7.
  - FIFO fills after 4 pushes.
  - Writes of A..D resume at T+8..T+11 in order at 0x100..0x103.
  - Exactly one done pulse, at T+12.
- Address wrap: base=0x3FE → writes to 0x3FE, 0x3FF, 0x000, 0x001.
- Ignored controls: set_address=0x200 and a second wb_start while busy → current operation still writes from the old base. After done, wb_start writes from the old base again.
- Reset mid-operation: assert reset after 2 writes → next cycle mem_we=0, busy=0. A subsequent wb_start with 4 results writes 0x000..0x003 and done pulses once.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared definitions for the MAU-to-MatRAM write-back path.
// Holds the default geometry (address width, element width, elements per
// lane), the write-back controller state type and the MatRAM address type.
package mau_pkg;

  localparam int MAU_ADDR_W     = 10;
  localparam int MAU_DATA_W     = 16;
  localparam int MAU_LANE_ELEMS = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } wb_state_t;

  typedef logic [MAU_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/matram_wb_fifo.sv
// Small synchronous result buffer for the write-back lane.
// First-word-visible: dout always shows the oldest stored element, so the
// consumer can use it in the same cycle it decides to pop.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (flushes pointers)
//   push, din   - store din at the tail (ignored when full)
//   pop         - drop the head element (ignored when empty)
//   dout        - current head element (don't-care when empty)
//   full, empty - occupancy flags
module matram_wb_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  // One extra pointer bit distinguishes full from empty when indices match.
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[PTR_W-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/matram_writeback_lane.sv
// MatRAM write-back lane: collects LANE_ELEMS result elements from one MAU
// output lane and writes them to MatRAM at base, base+1, ... (wrapping at the
// top of the address space), then pulses done for one cycle.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   set_address, address_in - load the base address (only while idle)
//   wb_start                - arm one write-back operation (only while idle)
//   res_valid, res_data     - MAU result element offered
//   res_ready               - element is accepted this cycle
//   mem_grant               - MatRAM write port free this cycle
//   mem_we, mem_addr,
//   mem_wdata               - MatRAM write request (addr/data valid with mem_we)
//   busy                    - operation in progress
//   done                    - one-cycle pulse after the final write
module matram_writeback_lane
  import mau_pkg::*;
#(
  parameter int ADDR_W     = MAU_ADDR_W,
  parameter int DATA_W     = MAU_DATA_W,
  parameter int LANE_ELEMS = MAU_LANE_ELEMS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_address,
  input  logic [ADDR_W-1:0] address_in,
  input  logic              wb_start,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_ready,
  input  logic              mem_grant,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done
);

  localparam int              CNT_W    = $clog2(LANE_ELEMS + 1);
  localparam logic [CNT_W-1:0] ELEMS    = CNT_W'(LANE_ELEMS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LANE_ELEMS - 1);

  // Address arithmetic is modulo 2^ADDR_W: the carry out is discarded.
  function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] b,
                                                  input logic [CNT_W-1:0]  off);
    return b + ADDR_W'(off);
  endfunction

  wb_state_t         state;
  wb_state_t         state_next;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  accept_cnt;
  logic [CNT_W-1:0]  write_idx;

  logic              active;
  logic              push;
  logic              last_write;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  assign active = (state == ACTIVE);
  assign busy   = active;

  // Readiness ignores a same-cycle pop so the path from mem_grant to
  // res_ready stays purely registered-state based.
  assign res_ready  = active && !fifo_full && (accept_cnt < ELEMS);
  assign push       = res_valid && res_ready;

  assign mem_we     = active && !fifo_empty && mem_grant;
  assign mem_addr   = wrap_addr(base, write_idx);
  assign mem_wdata  = fifo_head;
  assign last_write = mem_we && (write_idx == LAST_IDX);

  matram_wb_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (mem_we),
    .din   (res_data),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (wb_start)   state_next = ACTIVE;
      ACTIVE:  if (last_write) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The base survives completion so a repeated wb_start reuses it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      base       <= '0;
      accept_cnt <= '0;
      write_idx  <= '0;
      done       <= 1'b0;
    end else begin
      state <= state_next;
      done  <= last_write;
      if (state == IDLE) begin
        if (set_address) base <= address_in;
        if (wb_start) begin
          accept_cnt <= '0;
          write_idx  <= '0;
        end
      end else begin
        if (push)   accept_cnt <= accept_cnt + 1'b1;
        if (mem_we) write_idx  <= write_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matram_writeback_lane.sv
module tb_matram_writeback_lane;
  import mau_pkg::*;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 16;
  localparam int LANE_ELEMS = 4;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              set_address;
  logic [ADDR_W-1:0] address_in;
  logic              wb_start;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_ready;
  logic              mem_grant;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic              done;

  matram_writeback_lane #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .LANE_ELEMS (LANE_ELEMS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .set_address (set_address),
    .address_in  (address_in),
    .wb_start    (wb_start),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_ready   (res_ready),
    .mem_grant   (mem_grant),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: lane state after the upcoming clock edge.
  bit          m_valid = 0;
  bit          m_active;
  int          m_base;
  int          m_acc;
  int          m_wr;
  bit          m_done;
  logic [15:0] m_q[$];

  // Observed write log for directed literal checks.
  int          log_addr[$];
  logic [15:0] log_data[$];
  int          log_cyc[$];
  int          done_cnt;
  int          done_cyc;

  always @(negedge clk) begin
    bit e_ready;
    bit e_we;
    e_ready = m_active && (m_q.size() < FIFO_DEPTH) && (m_acc < LANE_ELEMS);
    e_we    = m_active && (m_q.size() > 0) && mem_grant;
    if (m_valid) begin
      chk("res_ready", {31'b0, res_ready}, {31'b0, e_ready});
      chk("mem_we",    {31'b0, mem_we},    {31'b0, e_we});
      chk("busy",      {31'b0, busy},      {31'b0, m_active});
      chk("done",      {31'b0, done},      {31'b0, m_done});
      if (e_we && mem_we) begin
        chk("mem_addr",  {22'b0, mem_addr},  32'((m_base + m_wr) % 1024));
        chk("mem_wdata", {16'b0, mem_wdata}, {16'b0, m_q[0]});
      end
    end
    if (mem_we === 1'b1) begin
      log_addr.push_back(int'(mem_addr));
      log_data.push_back(mem_wdata);
      log_cyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (reset) begin
      m_valid  = 1;
      m_active = 0;
      m_base   = 0;
      m_acc    = 0;
      m_wr     = 0;
      m_done   = 0;
      m_q.delete();
    end else if (m_valid) begin
      m_done = 0;
      if (!m_active) begin
        if (set_address) m_base = int'(address_in);
        if (wb_start) begin
          m_active = 1;
          m_acc    = 0;
          m_wr     = 0;
        end
      end else begin
        if (e_we) begin
          void'(m_q.pop_front());
          m_wr++;
          if (m_wr == LANE_ELEMS) begin
            m_active = 0;
            m_done   = 1;
          end
        end
        if (res_valid && e_ready) begin
          m_q.push_back(res_data);
          m_acc++;
        end
      end
    end
  end

  logic [15:0] opdata[4];

  // gmode: 0 grant always, 1 grant low for cycles T+1..T+7, 2 random grant.
  // perturb: set_address/wb_start pulses while busy.
  // rst_after: assert reset once this many writes have been seen (0 = never).
  task automatic run_op(input logic [9:0] b, input bit do_set, input int gmode,
                        input bit perturb, input int rst_after, output int t0);
    int idx  = 0;
    int wcnt = 0;
    bit got_done = 0;
    @(posedge clk); #1;
    set_address = do_set;
    address_in  = b;
    wb_start    = 1;
    res_valid   = 0;
    mem_grant   = 1;
    t0 = cyc;
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
    for (int k = 1; k <= 60 && !got_done; k++) begin
      @(posedge clk); #1;
      wb_start    = perturb && (k == 2 || k == 3);
      set_address = perturb && (k == 2);
      address_in  = perturb ? 10'h200 : b;
      case (gmode)
        0:       mem_grant = 1;
        1:       mem_grant = (k > 7);
        default: mem_grant = ($urandom_range(0, 2) != 0);
      endcase
      res_valid = (idx < LANE_ELEMS);
      res_data  = opdata[idx < LANE_ELEMS ? idx : 0];
      if (rst_after > 0 && wcnt == rst_after) begin
        reset     = 1;
        res_valid = 0;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("rst_mid_we",   {31'b0, mem_we}, 32'd0);
        chk("rst_mid_busy", {31'b0, busy},   32'd0);
        chk("rst_mid_done", {31'b0, done},   32'd0);
        return;
      end
      @(negedge clk);
      if (res_valid && res_ready) idx++;
      if (mem_we) wcnt++;
      if (done) got_done = 1;
    end
    @(posedge clk); #1;
    set_address = 0;
    wb_start    = 0;
    res_valid   = 0;
    chk("done_seen", {31'b0, got_done}, 32'd1);
  endtask

  // Writes must be base..base+3 (mod 1024) carrying opdata in order.
  task automatic check_log(input string tag, input int b, input int t0,
                           input int first_wr, input int done_off);
    chk({tag, "_nwrites"}, 32'(log_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      chk({tag, "_addr"}, 32'(log_addr[i]), 32'((b + i) % 1024));
      chk({tag, "_data"}, {16'b0, log_data[i]}, {16'b0, opdata[i]});
      if (first_wr >= 0) chk({tag, "_wcyc"}, 32'(log_cyc[i]), 32'(t0 + first_wr + i));
    end
    chk({tag, "_ndone"}, 32'(done_cnt), 32'd1);
    if (done_off >= 0) chk({tag, "_dcyc"}, 32'(done_cyc), 32'(t0 + done_off));
  endtask

  initial begin
    int t0;
    reset       = 1;
    set_address = 0;
    address_in  = '0;
    wb_start    = 0;
    res_valid   = 0;
    res_data    = '0;
    mem_grant   = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_ready", {31'b0, res_ready}, 32'd0);
    chk("rst_we",    {31'b0, mem_we},    32'd0);
    chk("rst_busy",  {31'b0, busy},      32'd0);
    chk("rst_done",  {31'b0, done},      32'd0);

    // No set_address since reset: base is 0.
    opdata = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    run_op(10'h155, 0, 0, 0, 0, t0);
    check_log("rstbase", 0, t0, 2, 6);

    // Back-to-back stream.
    opdata = '{16'hA0A1, 16'hB0B2, 16'hC0C3, 16'hD0D4};
    run_op(10'h100, 1, 0, 0, 0, t0);
    check_log("b2b", 'h100, t0, 2, 6);

    // Grant stall fills the FIFO.
    opdata = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
    run_op(10'h100, 1, 1, 0, 0, t0);
    check_log("stall", 'h100, t0, 8, 12);

    // Address wrap.
    opdata = '{16'hCAFE, 16'hBEEF, 16'hF00D, 16'hD00D};
    run_op(10'h3FE, 1, 0, 0, 0, t0);
    check_log("wrap", 'h3FE, t0, 2, 6);
    if (log_addr.size() == 4) begin
      chk("wrap_lit2", 32'(log_addr[2]), 32'h000);
      chk("wrap_lit3", 32'(log_addr[3]), 32'h001);
    end

    // Ignored controls while busy, then base reuse.
    opdata = '{16'h5A5A, 16'h6B6B, 16'h7C7C, 16'h8D8D};
    run_op(10'h100, 1, 0, 1, 0, t0);
    check_log("ignore", 'h100, t0, 2, 6);
    run_op(10'h2AA, 0, 0, 0, 0, t0);
    check_log("reuse", 'h100, t0, 2, 6);

    // Reset mid-operation, then a fresh op from base 0.
    run_op(10'h150, 1, 0, 0, 2, t0);
    opdata = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    run_op(10'h123, 0, 0, 0, 0, t0);
    check_log("postrst", 0, t0, 2, 6);

    // Random grant pattern with a known base.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) opdata[i] = 16'($urandom);
      run_op(10'($urandom), 1, 2, 0, 0, t0);
      chk("rnd_nwrites", 32'(log_addr.size()), 32'd4);
      chk("rnd_ndone",   32'(done_cnt),        32'd1);
    end

    // Fully random stimulus checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      reset       = ($urandom_range(0, 299) == 0);
      set_address = ($urandom_range(0, 3) == 0);
      address_in  = 10'($urandom);
      wb_start    = ($urandom_range(0, 5) == 0);
      res_valid   = ($urandom_range(0, 1) == 1);
      res_data    = 16'($urandom);
      mem_grant   = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    reset = 0; set_address = 0; wb_start = 0; res_valid = 0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
